// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register with a 2-entry skid buffer, writeback mux and zero-register guard.
// Latency: 1 cycle from accept to out_valid; head entry held until WB pops it.
// Backpressure: in_ready = !skid_valid (registered), so WB stalls never drop or reorder entries.
module mem_wb_skid_stage #(
  parameter int DATA_W     = 8,
  parameter int RD_W       = 5,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] readdata_in,
  input  logic [DATA_W-1:0] resultalu_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              memtoreg_in,
  input  logic              regwrite_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   rd_out,
  output logic              wb_en,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] resultalu;
    logic [RD_W-1:0]   rd;
    logic              memtoreg;
    logic              regwrite;
  } slot_t;

  slot_t m_dat, m_dat_nxt;
  slot_t s_dat, s_dat_nxt;
  slot_t in_dat;
  logic  m_vld, m_vld_nxt;
  logic  s_vld, s_vld_nxt;
  logic  accept;
  logic  pop;
  logic  rd_ok;

  assign in_dat   = {readdata_in, resultalu_in, rd_in, memtoreg_in, regwrite_in};
  assign in_ready = !s_vld;
  assign accept   = in_valid & in_ready;
  assign pop      = m_vld & out_ready;

  // Next-state for the main/skid slots; flush overrides every other transition.
  always_comb begin
    m_vld_nxt = m_vld;
    s_vld_nxt = s_vld;
    m_dat_nxt = m_dat;
    s_dat_nxt = s_dat;
    if (flush) begin
      m_vld_nxt = 1'b0;
      s_vld_nxt = 1'b0;
    end else if (s_vld) begin
      // Both slots full: nothing can be accepted, a pop promotes the skid entry.
      if (pop) begin
        m_dat_nxt = s_dat;
        s_vld_nxt = 1'b0;
      end
    end else if (m_vld) begin
      if (accept && pop) begin
        m_dat_nxt = in_dat;
      end else if (accept) begin
        s_dat_nxt = in_dat;
        s_vld_nxt = 1'b1;
      end else if (pop) begin
        m_vld_nxt = 1'b0;
      end
    end else if (accept) begin
      m_dat_nxt = in_dat;
      m_vld_nxt = 1'b1;
    end
  end

  // Slot registers; asynchronous reset clears valid bits and payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_dat <= '0;
      s_dat <= '0;
    end else begin
      m_vld <= m_vld_nxt;
      s_vld <= s_vld_nxt;
      m_dat <= m_dat_nxt;
      s_dat <= s_dat_nxt;
    end
  end

  // Outputs come only from the main slot and are masked while it is empty.
  assign out_valid = m_vld;
  assign wb_data   = m_vld ? (m_dat.memtoreg ? m_dat.readdata : m_dat.resultalu) : '0;
  assign rd_out    = m_vld ? m_dat.rd : '0;
  assign rd_ok     = ZERO_GUARD ? (m_dat.rd != '0) : 1'b1;
  assign wb_en     = pop & m_dat.regwrite & rd_ok;
  assign occupancy = {1'b0, m_vld} + {1'b0, s_vld};

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed bench for mem_wb_skid_stage: scoreboard on the default instance,
// with zero-guard-off and 16-bit instances run in lockstep on the same stimulus.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_mem_wb_skid_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] readdata16;
  logic [15:0] resultalu16;
  logic [4:0]  rd_in;
  logic        memtoreg_in;
  logic        regwrite_in;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, wb_en;
  logic [7:0]  wb_data;
  logic [4:0]  rd_out;
  logic [1:0]  occupancy;

  logic        nz_in_ready, nz_out_valid, nz_wb_en;
  logic [7:0]  nz_wb_data;
  logic [4:0]  nz_rd_out;
  logic [1:0]  nz_occupancy;

  logic        w_in_ready, w_out_valid, w_wb_en;
  logic [15:0] w_wb_data;
  logic [4:0]  w_rd_out;
  logic [1:0]  w_occupancy;

  typedef struct packed {
    logic [7:0] wb;
    logic [4:0] rd;
    logic       en;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_wb_skid_stage #(.DATA_W(8), .RD_W(5), .ZERO_GUARD(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .readdata_in(readdata16[7:0]), .resultalu_in(resultalu16[7:0]), .rd_in(rd_in),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data),
    .rd_out(rd_out), .wb_en(wb_en), .occupancy(occupancy)
  );

  mem_wb_skid_stage #(.DATA_W(8), .RD_W(5), .ZERO_GUARD(1'b0)) dut_nz (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nz_in_ready),
    .readdata_in(readdata16[7:0]), .resultalu_in(resultalu16[7:0]), .rd_in(rd_in),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .flush(flush),
    .out_valid(nz_out_valid), .out_ready(out_ready), .wb_data(nz_wb_data),
    .rd_out(nz_rd_out), .wb_en(nz_wb_en), .occupancy(nz_occupancy)
  );

  mem_wb_skid_stage #(.DATA_W(16), .RD_W(5), .ZERO_GUARD(1'b1)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .readdata_in(readdata16), .resultalu_in(resultalu16), .rd_in(rd_in),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .flush(flush),
    .out_valid(w_out_valid), .out_ready(out_ready), .wb_data(w_wb_data),
    .rd_out(w_rd_out), .wb_en(w_wb_en), .occupancy(w_occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [15:0] rdat, input logic [15:0] alu,
                        input logic [4:0] rd, input logic m2r, input logic rw);
    in_valid    = v;
    readdata16  = rdat;
    resultalu16 = alu;
    rd_in       = rd;
    memtoreg_in = m2r;
    regwrite_in = rw;
  endtask

  task automatic expect_out(input logic [7:0] wb, input logic [4:0] rd, input logic en);
    exp_t e;
    e.wb = wb;
    e.rd = rd;
    e.en = en;
    exp_q.push_back(e);
  endtask

  // Monitor: every WB pop is compared against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got wb_data %0h rd %0d, expected no output", wb_data, rd_out);
        end else begin
          e = exp_q.pop_front();
          chk("pop_wb_data", {24'd0, wb_data}, {24'd0, e.wb});
          chk("pop_rd_out",  {27'd0, rd_out},  {27'd0, e.rd});
          chk("pop_wb_en",   {31'd0, wb_en},   {31'd0, e.en});
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    cyc();
    cyc();
    at_neg();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wb_data",   {24'd0, wb_data},   32'd0);
    chk("rst_rd_out",    {27'd0, rd_out},    32'd0);
    chk("rst_wb_en",     {31'd0, wb_en},     32'd0);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    reset = 1'b1;
    cyc();

    // ALU result path, latency 1.
    out_ready = 1'b1;
    set_in(1'b1, 16'h0000, 16'h005A, 5'd3, 1'b0, 1'b1);
    expect_out(8'h5A, 5'd3, 1'b1);
    cyc();
    set_in(1'b0, 16'hFFFF, 16'hFFFF, 5'd31, 1'b1, 1'b1);
    at_neg();
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_occupancy", {30'd0, occupancy}, 32'd1);
    cyc();

    // Memory data path.
    set_in(1'b1, 16'h00C3, 16'h0011, 5'd4, 1'b1, 1'b1);
    expect_out(8'hC3, 5'd4, 1'b1);
    cyc();
    set_in(1'b0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    cyc();
    cyc();
    at_neg();
    chk("t2_drained", {30'd0, occupancy}, 32'd0);

    // Backpressure: A and B fill both slots, C refused until space frees.
    cyc();
    out_ready = 1'b0;
    set_in(1'b1, 16'h0, 16'h00A1, 5'd1, 1'b0, 1'b1);
    expect_out(8'hA1, 5'd1, 1'b1);
    cyc();
    set_in(1'b1, 16'h0, 16'h00B2, 5'd2, 1'b0, 1'b1);
    expect_out(8'hB2, 5'd2, 1'b1);
    cyc();
    set_in(1'b1, 16'h0, 16'h00C5, 5'd5, 1'b0, 1'b1);
    expect_out(8'hC5, 5'd5, 1'b1);
    at_neg();
    chk("t3_full_occ",   {30'd0, occupancy}, 32'd2);
    chk("t3_full_rdy",   {31'd0, in_ready},  32'd0);
    cyc();
    at_neg();
    chk("t3_refused_occ", {30'd0, occupancy}, 32'd2);
    chk("t3_refused_rd",  {27'd0, rd_out},    32'd1);
    cyc();
    out_ready = 1'b1;
    cyc();
    at_neg();
    chk("t3_after_pop_rdy", {31'd0, in_ready},  32'd1);
    chk("t3_after_pop_occ", {30'd0, occupancy}, 32'd1);
    cyc();
    set_in(1'b0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    cyc();
    at_neg();
    chk("t3_drained", {30'd0, occupancy}, 32'd0);
    chk("t3_queue",   exp_q.size(),       32'd0);

    // Flush with both slots held and an entry offered.
    cyc();
    out_ready = 1'b0;
    set_in(1'b1, 16'h0, 16'h00D6, 5'd6, 1'b0, 1'b1);
    cyc();
    set_in(1'b1, 16'h0, 16'h00E7, 5'd7, 1'b0, 1'b1);
    cyc();
    set_in(1'b1, 16'h0, 16'h0099, 5'd9, 1'b0, 1'b1);
    flush = 1'b1;
    at_neg();
    chk("t4_pre_flush_occ", {30'd0, occupancy}, 32'd2);
    cyc();
    flush = 1'b0;
    set_in(1'b0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    at_neg();
    chk("t4_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_flush_occ",   {30'd0, occupancy}, 32'd0);
    chk("t4_flush_rdy",   {31'd0, in_ready},  32'd1);

    // Flush while popping the head and accepting a new entry.
    cyc();
    out_ready = 1'b1;
    set_in(1'b1, 16'h0, 16'h0048, 5'd8, 1'b0, 1'b1);
    expect_out(8'h48, 5'd8, 1'b1);
    cyc();
    set_in(1'b1, 16'h0, 16'h006A, 5'd10, 1'b0, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    set_in(1'b0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    at_neg();
    chk("t4b_valid", {31'd0, out_valid}, 32'd0);
    chk("t4b_occ",   {30'd0, occupancy}, 32'd0);

    // Zero-register guard on and off; regwrite=0 never writes.
    cyc();
    set_in(1'b1, 16'h0, 16'h0077, 5'd0, 1'b0, 1'b1);
    expect_out(8'h77, 5'd0, 1'b0);
    cyc();
    set_in(1'b1, 16'h0, 16'h0066, 5'd2, 1'b0, 1'b0);
    expect_out(8'h66, 5'd2, 1'b0);
    at_neg();
    chk("t5_zg_valid",   {31'd0, out_valid},    32'd1);
    chk("t5_nz_wb_en",   {31'd0, nz_wb_en},     32'd1);
    chk("t5_nz_wb_data", {24'd0, nz_wb_data},   32'h77);
    cyc();
    set_in(1'b0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    at_neg();
    chk("t5_nz_norw_en", {31'd0, nz_wb_en}, 32'd0);
    cyc();

    // Wide datapath carries the full 16 bits.
    set_in(1'b1, 16'hBEEF, 16'h1234, 5'd3, 1'b1, 1'b1);
    expect_out(8'hEF, 5'd3, 1'b1);
    cyc();
    set_in(1'b0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    at_neg();
    chk("t6_w16_wb_data", {16'd0, w_wb_data}, 32'h0000BEEF);
    chk("t6_w16_wb_en",   {31'd0, w_wb_en},   32'd1);
    cyc();

    // Asynchronous reset with both slots held.
    out_ready = 1'b0;
    set_in(1'b1, 16'h0, 16'h002B, 5'd11, 1'b0, 1'b1);
    cyc();
    set_in(1'b1, 16'h0, 16'h003C, 5'd12, 1'b0, 1'b1);
    cyc();
    set_in(1'b0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    #2;
    chk("t7_pre_rst_occ", {30'd0, occupancy}, 32'd2);
    out_ready = 1'b1;
    reset     = 1'b0;
    exp_q.delete();
    #1;
    chk("t7_rst_valid", {31'd0, out_valid},   32'd0);
    chk("t7_rst_occ",   {30'd0, occupancy},   32'd0);
    chk("t7_rst_rdy",   {31'd0, in_ready},    32'd1);
    chk("t7_rst_data",  {24'd0, wb_data},     32'd0);
    chk("t7_rst_rd",    {27'd0, rd_out},      32'd0);
    chk("t7_rst_en",    {31'd0, wb_en},       32'd0);
    chk("t7_rst_w16",   {30'd0, w_occupancy}, 32'd0);
    at_neg();
    #1 reset = 1'b1;
    cyc();
    set_in(1'b1, 16'h0, 16'h005D, 5'd13, 1'b0, 1'b1);
    expect_out(8'h5D, 5'd13, 1'b1);
    cyc();
    set_in(1'b0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    at_neg();
    chk("t7_post_valid", {31'd0, out_valid}, 32'd1);
    chk("t7_post_occ",   {30'd0, occupancy}, 32'd1);
    cyc();
    cyc();
    at_neg();
    chk("end_queue_empty", exp_q.size(), 32'd0);
    chk("end_occ",         {30'd0, occupancy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
